rob_commit_sequencer: RTL and testbench
=======================================

// Module: rob_commit_sequencer
// PURPOSE
//  In-order commit controller for the MPT walker reorder buffer. Allocates transaction IDs to the
//  issue stage and tracks per-ID completion from the PLB/walking-stage retire ports. Releases
//  completed transactions to the commit stage strictly in allocation order, and pulses a per-port
//  clear towards the ROB memory that holds the retired entry.
// PARAMETERS
//  ROB_DEPTH   32  number of in-flight IDs; must be <= 2**ID_WIDTH-1 (all-ones ID is reserved as invalid)
//  PORT_NUM    4   number of retire (completion) ports
//  ID_WIDTH    mpt_pkg::ROB_ID_SIZE  width of a transaction ID
// PORTS
//  clk_i            in   1                   clock
//  rst_ni           in   1                   reset, asynchronous, active-low
//  flush_i          in   1                   synchronous flush of all in-flight IDs
//  alloc_valid_i    in   1                   issue stage requests an ID
//  alloc_ready_o    out  1                   ID available
//  alloc_id_o       out  ID_WIDTH            ID granted on alloc handshake
//  cmpl_valid_i     in   PORT_NUM            per-port completion strobe
//  cmpl_id_i        in   PORT_NUM*ID_WIDTH   per-port completed ID; port p uses bits [p*ID_WIDTH +: ID_WIDTH]
//  cmpl_err_i       in   PORT_NUM            per-port fault flag (format or access error)
//  commit_valid_o   out  1                   head transaction completed
//  commit_ready_i   in   1                   commit stage accepts
//  commit_id_o      out  ID_WIDTH            head ID
//  commit_port_o    out  $clog2(PORT_NUM)    port whose ROB memory holds the head entry
//  commit_err_o     out  1                   head fault flag
//  rob_clear_o      out  PORT_NUM            one-hot clear of entry commit_id_o in ROB memory of that port
//  cmpl_illegal_o   out  1                   registered pulse: a completion was rejected
//  usage_o          out  $clog2(ROB_DEPTH)+1 in-flight count
//  full_o/empty_o   out  1                   usage_o==ROB_DEPTH / usage_o==0
// BEHAVIOUR
//  - State: per-entry alloc, done, err and port[] bits; head and tail pointers (0..ROB_DEPTH-1);
//    count (0..ROB_DEPTH). No explicit FSM; the block is controlled by pointers and a counter.
//  - Reset (async): all state cleared. Outputs during and after reset: alloc_ready_o=1, alloc_id_o=0,
//    commit_valid_o=0, commit_id_o=0, commit_port_o=0, commit_err_o=0, rob_clear_o=0,
//    cmpl_illegal_o=0, usage_o=0, empty_o=1, full_o=0.
//  - Alloc: alloc_ready_o = (count<ROB_DEPTH) & ~flush_i; alloc_id_o = tail (combinational).
//    On handshake: alloc[tail]<=1, done[tail]<=0, tail<=(tail==ROB_DEPTH-1)?0:tail+1.
//  - Completion, port p accepted iff: valid; id!='1; id<ROB_DEPTH; alloc[id]; ~done[id];
//    and no lower-index port completes the same id in that cycle.
//    An accepted completion sets done, err and port[id]<=p at the next edge.
//    Any rejected valid completion raises cmpl_illegal_o for exactly 1 cycle, one cycle later.
//  - Commit: commit_valid_o = alloc[head] & done[head] & ~flush_i, driven from registers.
//    Latency: a completion accepted at edge t makes commit_valid_o high in the following cycle.
//    commit_id_o=head; commit_port_o/commit_err_o come from that entry. All are held stable while valid & ~ready.
//  - Commit handshake: clear alloc/done[head]; head advances with wrap; rob_clear_o[port[head]]=1 in
//    the same cycle (combinational).
//  - Alloc and commit in the same cycle: count unchanged. When full, alloc_ready_o is derived from
//    the registered count, so a same-cycle commit does not enable alloc.
//  - Out-of-order completion is allowed; commit stays in order (head blocks until its entry is done).
//  - flush_i: in that cycle alloc_ready_o=0, commit_valid_o=0, rob_clear_o=0, completions are ignored
//    and do not raise cmpl_illegal_o. At the next edge all entries, head, tail and count go to 0.
//  - Reset asserted mid-operation discards all in-flight IDs immediately.
// TESTING
//  1 Reset, then 3 allocs -> alloc_id_o 0,1,2; usage_o=3. Complete ID 0 on port 2 -> next cycle
//    commit_valid_o=1, id=0, port=2, rob_clear_o=4'b0100 on handshake.
//  2 Out of order: alloc 0..3, complete 3,1,2 then 0 -> commits exactly 0,1,2,3; no commit
//    before ID 0 completes.
//  3 Full/wrap (ROB_DEPTH=32): 32 allocs -> full_o=1, alloc_ready_o=0; commit 1 plus a same-cycle
//    alloc request -> alloc refused that cycle, accepted next with ID 0.
//  4 Illegal: complete unallocated ID 5, ID '1, and ID 0 on ports 0 and 1 simultaneously ->
//    cmpl_illegal_o pulses; ID 0 records port 0.
//  5 Backpressure: commit_ready_i=0 for 4 cycles with head done -> id/port/err stable, no clear pulse.
//  6 Flush with 10 in flight, plus async reset during a commit -> usage_o=0, empty_o=1,
//    next alloc_id_o=0, no commit.

Source files
------------

// File: rtl/rob_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Package      : mpt_pkg
// Description  : Shared sizing constants for the MPT walker reorder buffer.
// Revision     : 1.0 - initial release
// ============================================================================
package mpt_pkg;
  // 6 bits leave the all-ones value free as the reserved invalid ID for a
  // 32-entry buffer.
  localparam int ROB_ID_SIZE = 6;
endpackage

// ============================================================================
// Module       : rob_commit_sequencer
// Description  : In-order commit controller for the MPT walker reorder
//                buffer. Hands out transaction IDs to the issue stage,
//                records per-ID completion reported on the retire ports,
//                and releases completed transactions to the commit stage
//                strictly in allocation order. On every commit it pulses a
//                one-hot clear towards the ROB memory of the port that
//                holds the retired entry.
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   flush_i        synchronous flush of every in-flight ID
//   alloc_valid_i  issue stage requests an ID
//   alloc_ready_o  an ID is available (count below depth, no flush)
//   alloc_id_o     ID granted on the alloc handshake (tail pointer)
//   cmpl_valid_i   per-port completion strobe
//   cmpl_id_i      per-port completed ID, port p at [p*ID_WIDTH +: ID_WIDTH]
//   cmpl_err_i     per-port fault flag
//   commit_valid_o head transaction has completed
//   commit_ready_i commit stage accepts the head
//   commit_id_o    head ID
//   commit_port_o  port whose ROB memory holds the head entry
//   commit_err_o   head fault flag
//   rob_clear_o    one-hot clear of the committed entry, per port
//   cmpl_illegal_o registered pulse: a completion was rejected
//   usage_o        in-flight count
//   full_o         usage_o == ROB_DEPTH
//   empty_o        usage_o == 0
// ============================================================================
module rob_commit_sequencer #(
  parameter  int ROB_DEPTH = 32,
  parameter  int PORT_NUM  = 4,
  parameter  int ID_WIDTH  = mpt_pkg::ROB_ID_SIZE,
  localparam int PORT_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int CNT_W     = $clog2(ROB_DEPTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  output logic [ID_WIDTH-1:0]          alloc_id_o,
  input  logic [PORT_NUM-1:0]          cmpl_valid_i,
  input  logic [PORT_NUM*ID_WIDTH-1:0] cmpl_id_i,
  input  logic [PORT_NUM-1:0]          cmpl_err_i,
  output logic                         commit_valid_o,
  input  logic                         commit_ready_i,
  output logic [ID_WIDTH-1:0]          commit_id_o,
  output logic [PORT_W-1:0]            commit_port_o,
  output logic                         commit_err_o,
  output logic [PORT_NUM-1:0]          rob_clear_o,
  output logic                         cmpl_illegal_o,
  output logic [CNT_W-1:0]             usage_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int                   PTR_W      = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam logic [ID_WIDTH-1:0]  ID_INVALID = '1;
  localparam logic [ID_WIDTH-1:0]  DEPTH_ID   = ID_WIDTH'(ROB_DEPTH);
  localparam logic [CNT_W-1:0]     DEPTH_CNT  = CNT_W'(ROB_DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR   = PTR_W'(ROB_DEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ROB_DEPTH-1:0] alloc_q, alloc_d;
  logic [ROB_DEPTH-1:0] done_q,  done_d;
  logic [ROB_DEPTH-1:0] err_q,   err_d;
  logic [PORT_W-1:0]    port_q [ROB_DEPTH];
  logic [PORT_W-1:0]    port_d [ROB_DEPTH];
  logic [PTR_W-1:0]     head_q,  head_d;
  logic [PTR_W-1:0]     tail_q,  tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 illegal_q, illegal_d;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic alloc_ready;
  logic alloc_fire;
  logic commit_valid;
  logic commit_fire;

  // Readiness comes from the registered count only, so a commit in the same
  // cycle never frees a slot for an alloc while full.
  assign alloc_ready  = (count_q < DEPTH_CNT) && !flush_i;
  assign alloc_fire   = alloc_ready && alloc_valid_i;
  assign commit_valid = alloc_q[head_q] && done_q[head_q] && !flush_i;
  assign commit_fire  = commit_valid && commit_ready_i;

  // --------------------------------------------------------------------------
  // Completion qualification
  // --------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] cmpl_id  [PORT_NUM];
  logic [PTR_W-1:0]    cmpl_idx [PORT_NUM];
  logic [PORT_NUM-1:0] cmpl_legal;
  logic [PORT_NUM-1:0] cmpl_dup;
  logic [PORT_NUM-1:0] cmpl_acc;
  logic [PORT_NUM-1:0] cmpl_rej;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    assign cmpl_id[p]  = cmpl_id_i[p*ID_WIDTH +: ID_WIDTH];
    assign cmpl_idx[p] = cmpl_id[p][PTR_W-1:0];
    // The range test guards the truncated index used for the table lookup.
    assign cmpl_legal[p] = cmpl_valid_i[p]
                        && (cmpl_id[p] != ID_INVALID)
                        && (cmpl_id[p] <  DEPTH_ID)
                        && alloc_q[cmpl_idx[p]]
                        && !done_q[cmpl_idx[p]];
  end

  // A lower-index port wins when several ports report the same ID.
  always_comb begin
    cmpl_dup = '0;
    for (int p = 1; p < PORT_NUM; p++) begin
      for (int q = 0; q < p; q++) begin
        if (cmpl_valid_i[q] && (cmpl_id[q] == cmpl_id[p])) begin
          cmpl_dup[p] = 1'b1;
        end
      end
    end
  end

  // During a flush completions are dropped silently: neither accepted nor
  // counted as illegal.
  assign cmpl_acc  = cmpl_legal & ~cmpl_dup & {PORT_NUM{!flush_i}};
  assign cmpl_rej  = cmpl_valid_i & ~cmpl_acc & {PORT_NUM{!flush_i}};
  assign illegal_d = |cmpl_rej;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    err_d   = err_q;
    port_d  = port_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush_i) begin
      alloc_d = '0;
      done_d  = '0;
      err_d   = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        port_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Accepted completions, alloc and commit touch disjoint entries:
      // completions need an allocated not-done entry, commit needs a done
      // head, and alloc needs an unallocated tail.
      for (int p = 0; p < PORT_NUM; p++) begin
        if (cmpl_acc[p]) begin
          done_d[cmpl_idx[p]] = 1'b1;
          err_d[cmpl_idx[p]]  = cmpl_err_i[p];
          port_d[cmpl_idx[p]] = PORT_W'(p);
        end
      end

      if (commit_fire) begin
        alloc_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
      end

      if (alloc_fire) begin
        alloc_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        err_d[tail_q]   = 1'b0;
        tail_d          = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        port_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      port_q    <= port_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rob_clear_o = '0;
    if (commit_fire) begin
      rob_clear_o[port_q[head_q]] = 1'b1;
    end
  end

  assign alloc_ready_o  = alloc_ready;
  assign alloc_id_o     = ID_WIDTH'(tail_q);
  assign commit_valid_o = commit_valid;
  assign commit_id_o    = ID_WIDTH'(head_q);
  assign commit_port_o  = port_q[head_q];
  assign commit_err_o   = err_q[head_q];
  assign cmpl_illegal_o = illegal_q;
  assign usage_o        = count_q;
  assign full_o         = (count_q == DEPTH_CNT);
  assign empty_o        = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module       : tb_rob_commit_sequencer
// Description  : Self-checking bench for rob_commit_sequencer. Directed
//                scenarios followed by randomized traffic, all compared
//                against an in-order queue model of the reorder buffer.
// Revision     : 1.0 - initial release
// ============================================================================
module tb_rob_commit_sequencer;

  localparam int DEPTH = 32;
  localparam int P     = 4;
  localparam int W     = 6;
  localparam int PW    = 2;
  localparam int CW    = 6;

  logic           clk_i;
  logic           rst_ni;
  logic           flush_i;
  logic           alloc_valid_i;
  logic           alloc_ready_o;
  logic [W-1:0]   alloc_id_o;
  logic [P-1:0]   cmpl_valid_i;
  logic [P*W-1:0] cmpl_id_i;
  logic [P-1:0]   cmpl_err_i;
  logic           commit_valid_o;
  logic           commit_ready_i;
  logic [W-1:0]   commit_id_o;
  logic [PW-1:0]  commit_port_o;
  logic           commit_err_o;
  logic [P-1:0]   rob_clear_o;
  logic           cmpl_illegal_o;
  logic [CW-1:0]  usage_o;
  logic           full_o;
  logic           empty_o;

  rob_commit_sequencer #(
    .ROB_DEPTH (DEPTH),
    .PORT_NUM  (P),
    .ID_WIDTH  (W)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_id_o     (alloc_id_o),
    .cmpl_valid_i   (cmpl_valid_i),
    .cmpl_id_i      (cmpl_id_i),
    .cmpl_err_i     (cmpl_err_i),
    .commit_valid_o (commit_valid_o),
    .commit_ready_i (commit_ready_i),
    .commit_id_o    (commit_id_o),
    .commit_port_o  (commit_port_o),
    .commit_err_o   (commit_err_o),
    .rob_clear_o    (rob_clear_o),
    .cmpl_illegal_o (cmpl_illegal_o),
    .usage_o        (usage_o),
    .full_o         (full_o),
    .empty_o        (empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: IDs in flight kept in allocation order.
  // --------------------------------------------------------------------------
  int mq[$];
  int m_tail;
  bit m_done [DEPTH];
  bit m_err  [DEPTH];
  int m_port [DEPTH];
  bit m_ill;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_done[i] = 1'b0;
      m_err[i]  = 1'b0;
      m_port[i] = 0;
    end
    m_ill = 1'b0;
  endtask

  function automatic bit in_flight(input int id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [P*W-1:0] mk_ids(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // One clock cycle: drive at the falling edge, check against the model
  // shortly after, then advance the model to the state after the next rising edge.
  task automatic step(input logic av, input logic cr, input logic fl,
                      input logic [P-1:0] cv, input logic [P*W-1:0] ids,
                      input logic [P-1:0] ce);
    int sz, head, id;
    bit exp_cv, fire, aready, afire, rej, ok;
    bit acc [P];
    int acc_id [P];
    int seen[$];
    logic [P-1:0] exp_clr;

    @(negedge clk_i);
    alloc_valid_i  = av;
    commit_ready_i = cr;
    flush_i        = fl;
    cmpl_valid_i   = cv;
    cmpl_id_i      = ids;
    cmpl_err_i     = ce;
    #1;

    sz     = mq.size();
    head   = (m_tail - sz + DEPTH) % DEPTH;
    exp_cv = 1'b0;
    if (sz > 0 && !fl) exp_cv = m_done[mq[0]];
    fire    = exp_cv && cr;
    exp_clr = '0;
    if (fire) exp_clr = P'(1 << m_port[mq[0]]);
    aready = (sz < DEPTH) && !fl;
    afire  = aready && av;

    rej = 1'b0;
    for (int p = 0; p < P; p++) begin
      acc[p]    = 1'b0;
      acc_id[p] = 0;
      if (cv[p]) begin
        id = int'(ids[p*W +: W]);
        if (!fl) begin
          ok = (id != (1 << W) - 1) && (id < DEPTH) && in_flight(id);
          if (ok && m_done[id]) ok = 1'b0;
          foreach (seen[i]) if (seen[i] == id) ok = 1'b0;
          if (ok) begin
            acc[p]    = 1'b1;
            acc_id[p] = id;
          end else begin
            rej = 1'b1;
          end
        end
        seen.push_back(id);
      end
    end

    check_val("usage",        32'(usage_o),        32'(sz));
    check_val("full",         32'(full_o),         32'(sz == DEPTH));
    check_val("empty",        32'(empty_o),        32'(sz == 0));
    check_val("alloc_ready",  32'(alloc_ready_o),  32'(aready));
    check_val("alloc_id",     32'(alloc_id_o),     32'(m_tail));
    check_val("commit_valid", 32'(commit_valid_o), 32'(exp_cv));
    check_val("commit_id",    32'(commit_id_o),    32'(head));
    check_val("rob_clear",    32'(rob_clear_o),    32'(exp_clr));
    check_val("illegal",      32'(cmpl_illegal_o), 32'(m_ill));
    if (exp_cv) begin
      check_val("commit_port", 32'(commit_port_o), 32'(m_port[mq[0]]));
      check_val("commit_err",  32'(commit_err_o),  32'(m_err[mq[0]]));
    end

    if (fl) begin
      model_reset();
    end else begin
      for (int p = 0; p < P; p++) begin
        if (acc[p]) begin
          m_done[acc_id[p]] = 1'b1;
          m_err[acc_id[p]]  = ce[p];
          m_port[acc_id[p]] = p;
        end
      end
      if (fire) begin
        m_done[mq[0]] = 1'b0;
        void'(mq.pop_front());
      end
      if (afire) begin
        mq.push_back(m_tail);
        m_done[m_tail] = 1'b0;
        m_tail = (m_tail + 1) % DEPTH;
      end
      m_ill = rej;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rand_step(input int pa, input int pr);
    logic [P-1:0]   cv, ce;
    logic [P*W-1:0] ids;
    int r, id;
    ids = '0;
    for (int p = 0; p < P; p++) begin
      cv[p] = ($urandom_range(0, 99) < 40);
      ce[p] = $urandom_range(0, 1) == 1;
      r = int'($urandom_range(0, 9));
      if (r < 6 && mq.size() > 0) id = mq[$urandom_range(0, mq.size() - 1)];
      else if (r < 8 || p == 0)   id = int'($urandom_range(0, 63));
      else                        id = int'(ids[W-1:0]);
      ids[p*W +: W] = W'(id);
    end
    step($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pr,
         $urandom_range(0, 199) == 0, cv, ids, ce);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_ni         = 1'b0;
    flush_i        = 1'b0;
    alloc_valid_i  = 1'b0;
    commit_ready_i = 1'b0;
    cmpl_valid_i   = '0;
    cmpl_id_i      = '0;
    cmpl_err_i     = '0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk_i);
    #1;
    check_val("rst_alloc_ready",  32'(alloc_ready_o),  32'd1);
    check_val("rst_alloc_id",     32'(alloc_id_o),     32'd0);
    check_val("rst_commit_valid", 32'(commit_valid_o), 32'd0);
    check_val("rst_commit_id",    32'(commit_id_o),    32'd0);
    check_val("rst_commit_port",  32'(commit_port_o),  32'd0);
    check_val("rst_commit_err",   32'(commit_err_o),   32'd0);
    check_val("rst_rob_clear",    32'(rob_clear_o),    32'd0);
    check_val("rst_illegal",      32'(cmpl_illegal_o), 32'd0);
    check_val("rst_usage",        32'(usage_o),        32'd0);
    check_val("rst_empty",        32'(empty_o),        32'd1);
    check_val("rst_full",         32'(full_o),         32'd0);
    rst_ni = 1'b1;

    // Basic alloc / complete / commit
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 4'b0100, mk_ids(0, 0, 0, 0), '0);
    check_val("t1_usage", 32'(usage_o), 32'd3);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0);
    check_val("t1_commit_id",   32'(commit_id_o),   32'd0);
    check_val("t1_commit_port", 32'(commit_port_o), 32'd2);
    check_val("t1_rob_clear",   32'(rob_clear_o),   32'b0100);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Out-of-order completion, in-order commit
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 4'b0010, mk_ids(0, 3, 0, 0), '0);
    check_val("t2_no_commit", 32'(commit_valid_o), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'b0001, mk_ids(1, 0, 0, 0), '0);
    check_val("t2_no_commit", 32'(commit_valid_o), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'b1000, mk_ids(0, 0, 0, 2), '0);
    check_val("t2_no_commit", 32'(commit_valid_o), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'b0001, mk_ids(0, 0, 0, 0), '0);
    check_val("t2_no_commit", 32'(commit_valid_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0, '0);
      check_val("t2_commit_valid", 32'(commit_valid_o), 32'd1);
      check_val("t2_commit_id",    32'(commit_id_o),    32'(k));
    end
    idle(1);
    check_val("t2_empty", 32'(empty_o), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Full and wrap
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 1'b0, (i == 1) ? 4'b0001 : 4'b0000, mk_ids(0, 0, 0, 0), '0);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0);
    check_val("t3_full",         32'(full_o),         32'd1);
    check_val("t3_alloc_refuse", 32'(alloc_ready_o),  32'd0);
    check_val("t3_commit_valid", 32'(commit_valid_o), 32'd1);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check_val("t3_alloc_ready", 32'(alloc_ready_o), 32'd1);
    check_val("t3_alloc_id",    32'(alloc_id_o),    32'd0);
    check_val("t3_usage",       32'(usage_o),       32'd31);
    idle(1);
    check_val("t3_full_again", 32'(full_o), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Illegal completions, then backpressure on the head
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 4'b1111, mk_ids(0, 0, 5, 63), 4'b0001);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, '0);
      if (k == 0) check_val("t4_illegal", 32'(cmpl_illegal_o), 32'd1);
      check_val("t5_commit_id",   32'(commit_id_o),   32'd0);
      check_val("t5_commit_port", 32'(commit_port_o), 32'd0);
      check_val("t5_commit_err",  32'(commit_err_o),  32'd1);
      check_val("t5_no_clear",    32'(rob_clear_o),   32'd0);
    end
    step(1'b0, 1'b1, 1'b0, '0, '0, '0);
    check_val("t5_clear", 32'(rob_clear_o), 32'b0001);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Flush with 10 in flight
    repeat (10) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 4'b0001, mk_ids(0, 0, 0, 0), '0);
    step(1'b1, 1'b1, 1'b1, 4'b0011, mk_ids(1, 40, 0, 0), '0);
    idle(1);
    check_val("t6_usage",        32'(usage_o),        32'd0);
    check_val("t6_empty",        32'(empty_o),        32'd1);
    check_val("t6_alloc_id",     32'(alloc_id_o),     32'd0);
    check_val("t6_commit_valid", 32'(commit_valid_o), 32'd0);
    check_val("t6_illegal",      32'(cmpl_illegal_o), 32'd0);

    // Asynchronous reset in the middle of a commit
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 4'b1000, mk_ids(0, 0, 0, 0), '0);
    @(negedge clk_i);
    commit_ready_i = 1'b1;
    cmpl_valid_i   = '0;
    #1;
    check_val("t6_pre_commit", 32'(commit_valid_o), 32'd1);
    check_val("t6_pre_clear",  32'(rob_clear_o),    32'b1000);
    #1 rst_ni = 1'b0;
    #1;
    check_val("t6_rst_usage",  32'(usage_o),        32'd0);
    check_val("t6_rst_empty",  32'(empty_o),        32'd1);
    check_val("t6_rst_commit", 32'(commit_valid_o), 32'd0);
    check_val("t6_rst_clear",  32'(rob_clear_o),    32'd0);
    check_val("t6_rst_id",     32'(alloc_id_o),     32'd0);
    model_reset();
    commit_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0);

    // Randomized traffic in phases with differing alloc / commit pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        case (ph)
          0:       rand_step(85, 25);
          1:       rand_step(50, 50);
          2:       rand_step(25, 90);
          default: rand_step(90, 90);
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
